magnetron_ctrl: RTL and testbench
=================================

Name: magnetron_ctrl

Overview:
- Clocked, parametrised successor to the latch-based magnetron enable.
- Adds internal countdown timer, power-level duty cycling, pause/resume and a door safety interlock.
- Sits between the front-panel button/door inputs and the magnetron driver.
- Buttons are active-low levels, edge-detected internally.

Parameters:
- TIME_W, 16, width of the cook-time counter in seconds.
- TICK_DIV, 50000000, clk cycles per second tick (min 2).
- PWR_LEVELS, 10, power steps; also the duty-cycle window length in seconds.
- PWR_W, 4, width of power_in (must hold PWR_LEVELS).
- BEEP_SECS, 3, beep duration in seconds after completion (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- startn  in  1  start/resume button, active low.
- stopn  in  1  pause button, active low.
- clearn  in  1  clear/cancel button, active low.
- door_closed  in  1  1 = door closed.
- time_load  in  1  1-cycle strobe; loads time_in and power_in.
- time_in  in  TIME_W  cook time in seconds.
- power_in  in  PWR_W  power level, 0..PWR_LEVELS.
- mag_on  out  1  magnetron enable.
- remaining  out  TIME_W  seconds left.
- state  out  2  0=IDLE, 1=COOK, 2=PAUSED, 3=DONE.
- done  out  1  1-cycle pulse on completion.
- beep  out  1  buzzer drive.

Behaviour:
- Reset values:
  - state=IDLE, remaining=0, power=PWR_LEVELS.
  - Prescaler=0, pwm_cnt=0, mag_en=0, done=0, beep=0.
  - Button history registers=1 (released).
- Button events:
  - An event is a registered falling edge: prev=1, now=0.
  - One event per press; holding a button generates nothing further.
- Event priority within a cycle: clear > door open > stop > start > second tick.
- Second tick:
  - Prescaler counts only in COOK, wrapping at TICK_DIV-1.
  - sec_tick is a 1-cycle pulse at the wrap.
  - Prescaler holds in PAUSED; it is cleared on IDLE/DONE entry and on time_load.
- Load:
  - time_load is accepted in IDLE and PAUSED; ignored in COOK and DONE.
  - remaining <= time_in.
  - power <= min(power_in, PWR_LEVELS).
  - pwm_cnt <= 0.
- IDLE:
  - start with remaining!=0 and door_closed -> COOK.
  - start is ignored otherwise.
- COOK:
  - On sec_tick, remaining decrements and pwm_cnt increments, wrapping at PWR_LEVELS-1.
  - If remaining==1 at sec_tick: remaining <= 0, -> DONE, done=1 for that one cycle.
  - stop -> PAUSED.
  - door_closed=0 -> PAUSED.
- PAUSED:
  - start with door_closed and remaining!=0 -> COOK; the prescaler resumes from its held value.
- DONE:
  - start, clear or door open -> IDLE.
- clear, from any state -> IDLE: remaining <= 0, power <= PWR_LEVELS.
- Duty cycle:
  - mag_en is registered: (next state==COOK) && (next pwm_cnt < power).
  - power=0 means the timer runs with the magnetron never on.
  - power=PWR_LEVELS means continuously on.
- Safety:
  - mag_on = mag_en & door_closed, combinational.
  - Door opening drops mag_on in the same cycle, independent of state update.
- Reset mid-cook: mag_on drops asynchronously and all registers return to reset values.
- No wrap-around: remaining never decrements below 0.

Optional Feature:
- Macro: MAGNETRON_BEEP_EN.
- Defined:
  - On the DONE entry, beep=1 for BEEP_SECS seconds, counted with the prescaler running during DONE.
  - beep clears early on leaving DONE, or on clear/reset.
- Undefined:
  - beep is tied to 0.
  - No beep counter is built.
  - Prescaler does not run in DONE.

Test Plan (TICK_DIV=4, PWR_LEVELS=10, PWR_W=4):
1. Reset asserted mid-COOK with mag_on=1 -> mag_on=0 immediately; state=0, remaining=0; all outputs at reset values after release.
2. Load time_in=3, power_in=10, door closed, pulse startn -> state=1, mag_on=1; remaining steps 3,2,1 every 4 cycles; done pulses 1 cycle with remaining 0; state=3, mag_on=0.
3. Load time_in=20, power_in=3, start -> mag_on high for seconds 0-2 and low for seconds 3-9 of each 10 s window; power_in=15 clamps to 10, always on.
4. COOK with remaining=5, open door -> mag_on=0 the same cycle, state=2, remaining frozen; close door, no start -> stays 2; pulse start -> state=1, countdown resumes.
5. Press startn and clearn in the same cycle while in IDLE with remaining=5 -> clear wins: state=0, remaining=0; hold startn low 20 cycles -> only one start event.
6. MAGNETRON_BEEP_EN defined, BEEP_SECS=3, cook 2 s -> beep=1 for 12 cycles after done, then 0; repeat with a door open during the beep -> beep=0 immediately and state=0.

Source files
------------

// File: rtl/magnetron_ctrl.sv
// -----------------------------------------------------------------------------
// magnetron_ctrl
//   Clocked magnetron enable controller for a microwave front panel.
//   It has a cook-time countdown in seconds, power-level duty cycling over a
//   window of PWR_LEVELS seconds, pause/resume, and a door safety interlock.
//   Buttons are active-low levels. Each press is turned into a single event on
//   its falling edge.
//
//   Optional feature: define MAGNETRON_BEEP_EN to drive the buzzer for
//   BEEP_SECS seconds after completion. When it is not defined, beep is tied
//   to 0 and the prescaler stops in DONE.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   startn       start/resume button, active low
//   stopn        pause button, active low
//   clearn       clear/cancel button, active low
//   door_closed  1 = door closed
//   time_load    1-cycle strobe that loads time_in/power_in (IDLE or PAUSED)
//   time_in      cook time in seconds
//   power_in     power level 0..PWR_LEVELS (larger values clamp)
//   mag_on       magnetron enable, gated combinationally by door_closed
//   remaining    seconds left
//   state        0=IDLE 1=COOK 2=PAUSED 3=DONE
//   done         1-cycle pulse on completion
//   beep         buzzer drive
// -----------------------------------------------------------------------------
module magnetron_ctrl #(
    parameter int TIME_W     = 16,
    parameter int TICK_DIV   = 50000000,
    parameter int PWR_LEVELS = 10,
    parameter int PWR_W      = 4,
    parameter int BEEP_SECS  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startn,
    input  logic              stopn,
    input  logic              clearn,
    input  logic              door_closed,
    input  logic              time_load,
    input  logic [TIME_W-1:0] time_in,
    input  logic [PWR_W-1:0]  power_in,
    output logic              mag_on,
    output logic [TIME_W-1:0] remaining,
    output logic [1:0]        state,
    output logic              done,
    output logic              beep
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COOK   = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int                PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PWR_W-1:0]  PWR_MAX  = PWR_W'(PWR_LEVELS);
    localparam logic [PWR_W-1:0]  PWM_LAST = PWR_W'(PWR_LEVELS - 1);
    localparam logic [TIME_W-1:0] ONE_SEC  = TIME_W'(1);

    state_t              state_q, state_n;
    logic [TIME_W-1:0]   remaining_q, remaining_n;
    logic [PWR_W-1:0]    power_q, power_n;
    logic [PWR_W-1:0]    pwm_q, pwm_n;
    logic [PRE_W-1:0]    presc_q, presc_n;
    logic                mag_en_q, mag_en_n;
    logic                done_q, done_n;
    logic                start_prev, stop_prev, clear_prev;
    logic                start_ev, stop_ev, clear_ev;
    logic                load_ok, pre_run, sec_tick;

    // A press is the cycle where the previous sample was released and the
    // current one is pressed, so a held button yields exactly one event.
    assign start_ev = start_prev & ~startn;
    assign stop_ev  = stop_prev  & ~stopn;
    assign clear_ev = clear_prev & ~clearn;

    assign load_ok = time_load && (state_q == IDLE || state_q == PAUSED);

`ifdef MAGNETRON_BEEP_EN
    // The beep duration is timed with the same prescaler, so it runs in DONE.
    assign pre_run = (state_q == COOK) || (state_q == DONE);
`else
    assign pre_run = (state_q == COOK);
`endif
    assign sec_tick = pre_run && (presc_q == PRE_LAST);

    always_comb begin
        state_n     = state_q;
        remaining_n = remaining_q;
        power_n     = power_q;
        pwm_n       = pwm_q;
        presc_n     = presc_q;
        done_n      = 1'b0;

        if (load_ok) begin
            remaining_n = time_in;
            power_n     = (power_in > PWR_MAX) ? PWR_MAX : power_in;
            pwm_n       = '0;
        end

        // Priority: clear > door open > stop > start > second tick.
        if (clear_ev) begin
            state_n     = IDLE;
            remaining_n = '0;
            power_n     = PWR_MAX;
        end else begin
            case (state_q)
                IDLE, PAUSED: begin
                    if (start_ev && door_closed && remaining_n != '0)
                        state_n = COOK;
                end
                COOK: begin
                    if (!door_closed || stop_ev) begin
                        state_n = PAUSED;
                    end else if (sec_tick) begin
                        pwm_n = (pwm_q == PWM_LAST) ? '0 : pwm_q + 1'b1;
                        if (remaining_q == ONE_SEC) begin
                            remaining_n = '0;
                            state_n     = DONE;
                            done_n      = 1'b1;
                        end else if (remaining_q != '0) begin
                            remaining_n = remaining_q - ONE_SEC;
                        end
                    end
                end
                DONE: begin
                    if (!door_closed || start_ev)
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end

        // A pause holds the phase within the current second, so resuming
        // continues where it left off. Only IDLE/DONE entry and a load restart it.
        if (load_ok || (state_n != state_q && (state_n == IDLE || state_n == DONE)))
            presc_n = '0;
        else if (pre_run && state_n == state_q)
            presc_n = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
    end

    assign mag_en_n = (state_n == COOK) && (pwm_n < power_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            power_q     <= PWR_MAX;
            pwm_q       <= '0;
            presc_q     <= '0;
            mag_en_q    <= 1'b0;
            done_q      <= 1'b0;
            start_prev  <= 1'b1;
            stop_prev   <= 1'b1;
            clear_prev  <= 1'b1;
        end else begin
            state_q     <= state_n;
            remaining_q <= remaining_n;
            power_q     <= power_n;
            pwm_q       <= pwm_n;
            presc_q     <= presc_n;
            mag_en_q    <= mag_en_n;
            done_q      <= done_n;
            start_prev  <= startn;
            stop_prev   <= stopn;
            clear_prev  <= clearn;
        end
    end

`ifdef MAGNETRON_BEEP_EN
    localparam int                   BCNT_W    = $clog2(BEEP_SECS + 1);
    localparam logic [BCNT_W-1:0]    BEEP_LAST = BCNT_W'(BEEP_SECS - 1);

    logic              beep_q;
    logic [BCNT_W-1:0] beep_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
        end else if (state_n == DONE && state_q != DONE) begin
            beep_q     <= 1'b1;
            beep_cnt_q <= '0;
        end else if (state_n != DONE) begin
            beep_q     <= 1'b0;
        end else if (beep_q && sec_tick) begin
            if (beep_cnt_q == BEEP_LAST)
                beep_q <= 1'b0;
            else
                beep_cnt_q <= beep_cnt_q + 1'b1;
        end
    end

    assign beep = beep_q;
`else
    assign beep = 1'b0;
`endif

    // The door gates the enable without waiting for a clock edge.
    assign mag_on    = mag_en_q & door_closed;
    assign remaining = remaining_q;
    assign state     = state_q;
    assign done      = done_q;

endmodule

// File: tb/tb_magnetron_ctrl.sv
// -----------------------------------------------------------------------------
// tb_magnetron_ctrl
//   Scoreboard bench for magnetron_ctrl (TICK_DIV=4, PWR_LEVELS=10, PWR_W=4).
//   The driver applies inputs shortly after each rising edge. It advances a
//   behavioural reference model and pushes the expected outputs for that
//   cycle. The monitor pops one entry on each falling edge and compares it
//   with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_magnetron_ctrl;

    localparam int TW = 16;
    localparam int TD = 4;
    localparam int PL = 10;
    localparam int PW = 4;
    localparam int BS = 3;
`ifdef MAGNETRON_BEEP_EN
    localparam bit BEEP_ON = 1'b1;
`else
    localparam bit BEEP_ON = 1'b0;
`endif

    localparam int S_IDLE = 0, S_COOK = 1, S_PAUSED = 2, S_DONE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
    logic          door_closed = 1'b1, time_load = 1'b0;
    logic [TW-1:0] time_in = '0;
    logic [PW-1:0] power_in = '0;
    logic          mag_on, done, beep;
    logic [TW-1:0] remaining;
    logic [1:0]    state;

    // Values applied on the next call to step().
    logic          n_rst = 1'b1, n_startn = 1'b1, n_stopn = 1'b1, n_clearn = 1'b1;
    logic          n_door = 1'b1, n_load = 1'b0;
    logic [TW-1:0] n_time = '0;
    logic [PW-1:0] n_power = '0;

    always #5 clk = ~clk;

    magnetron_ctrl #(
        .TIME_W(TW), .TICK_DIV(TD), .PWR_LEVELS(PL), .PWR_W(PW), .BEEP_SECS(BS)
    ) dut (
        .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .time_load(time_load), .time_in(time_in),
        .power_in(power_in), .mag_on(mag_on), .remaining(remaining),
        .state(state), .done(done), .beep(beep)
    );

    // Reference model state.
    int m_state, m_rem, m_pwr, m_pre, m_pwm, m_en, m_done, m_beep, m_bsec;
    int m_sp, m_tp, m_cp;

    typedef struct {
        int st;
        int rem;
        int mag;
        int dn;
        int bp;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        m_state = S_IDLE; m_rem = 0; m_pwr = PL; m_pre = 0; m_pwm = 0;
        m_en = 0; m_done = 0; m_beep = 0; m_bsec = 0;
        m_sp = 1; m_tp = 1; m_cp = 1;
    endtask

    // One second of cook time passes every TD cycles spent cooking.
    // Within the PL-second window, seconds [0, power) have the magnetron on.
    task automatic model_step();
        int  nxt, rem, pw, pwm;
        bit  ev_s, ev_p, ev_c, loaded, running, tick;
        if (rst) begin
            model_reset();
            return;
        end
        ev_s = (m_sp == 1) && !startn;
        ev_p = (m_tp == 1) && !stopn;
        ev_c = (m_cp == 1) && !clearn;
        nxt = m_state; rem = m_rem; pw = m_pwr; pwm = m_pwm;
        m_done = 0;
        loaded = time_load && (m_state == S_IDLE || m_state == S_PAUSED);
        if (loaded) begin
            rem = int'(time_in);
            pw  = (int'(power_in) > PL) ? PL : int'(power_in);
            pwm = 0;
        end
        running = (m_state == S_COOK) || (BEEP_ON && m_state == S_DONE);
        tick    = running && (m_pre == TD - 1);

        if (ev_c) begin
            nxt = S_IDLE; rem = 0; pw = PL;
        end else if (!door_closed && m_state == S_COOK) begin
            nxt = S_PAUSED;
        end else if (!door_closed && m_state == S_DONE) begin
            nxt = S_IDLE;
        end else if (ev_p && m_state == S_COOK) begin
            nxt = S_PAUSED;
        end else if (ev_s && m_state == S_DONE) begin
            nxt = S_IDLE;
        end else if (ev_s && (m_state == S_IDLE || m_state == S_PAUSED)) begin
            if (rem > 0 && door_closed) nxt = S_COOK;
        end else if (tick && m_state == S_COOK) begin
            pwm = (pwm + 1) % PL;
            if (rem == 1) begin
                rem = 0; nxt = S_DONE; m_done = 1;
            end else if (rem > 1) begin
                rem = rem - 1;
            end
        end

        if (loaded || (nxt != m_state && (nxt == S_IDLE || nxt == S_DONE)))
            m_pre = 0;
        else if (running && nxt == m_state)
            m_pre = (m_pre + 1) % TD;

        if (BEEP_ON) begin
            if (nxt == S_DONE && m_state != S_DONE) begin
                m_beep = 1; m_bsec = 0;
            end else if (nxt != S_DONE) begin
                m_beep = 0;
            end else if (m_beep == 1 && tick) begin
                m_bsec = m_bsec + 1;
                if (m_bsec >= BS) m_beep = 0;
            end
        end

        m_state = nxt; m_rem = rem; m_pwr = pw; m_pwm = pwm;
        m_en = (nxt == S_COOK && pwm < pw) ? 1 : 0;
        m_sp = int'(startn); m_tp = int'(stopn); m_cp = int'(clearn);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        model_step();
        #1;
        rst = n_rst; startn = n_startn; stopn = n_stopn; clearn = n_clearn;
        door_closed = n_door; time_load = n_load; time_in = n_time; power_in = n_power;
        if (rst) model_reset();
        e.st  = m_state;
        e.rem = m_rem;
        e.mag = (m_en == 1 && door_closed) ? 1 : 0;
        e.dn  = m_done;
        e.bp  = m_beep;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int t, input int p);
        n_load = 1'b1; n_time = TW'(t); n_power = PW'(p);
        step();
        n_load = 1'b0;
    endtask

    task automatic press_start();
        n_startn = 1'b0; step(); n_startn = 1'b1; step();
    endtask

    task automatic press_stop();
        n_stopn = 1'b0; step(); n_stopn = 1'b1; step();
    endtask

    task automatic press_clear();
        n_clearn = 1'b0; step(); n_clearn = 1'b1; step();
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Monitor: the DUT presents a full set of outputs every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("state",     int'(state),     e.st);
                chk("remaining", int'(remaining), e.rem);
                chk("mag_on",    int'(mag_on),    e.mag);
                chk("done",      int'(done),      e.dn);
                chk("beep",      int'(beep),      e.bp);
            end
        end
    end

    initial begin
        model_reset();
        // Power-on reset, then release.
        idle(2);
        n_rst = 1'b0;
        idle(3);

        // Full-power 3 s cook to completion, then leave DONE with a clear.
        load(3, 10);
        press_start();
        idle(20);
        press_clear();

        // Power 3: on for 3 s of every 10 s window.
        load(20, 3);
        press_start();
        idle(50);
        press_clear();

        // Power 15 clamps to full power.
        load(8, 15);
        press_start();
        idle(20);
        press_clear();

        // Door opened mid-cook, closed without a start, then resumed.
        load(5, 10);
        press_start();
        idle(6);
        n_door = 1'b0; idle(3);
        n_door = 1'b1; idle(6);
        press_start();
        idle(24);
        press_clear();

        // Start and clear together: clear wins.
        load(5, 10);
        n_startn = 1'b0; n_clearn = 1'b0; step();
        n_startn = 1'b1; n_clearn = 1'b1; idle(2);
        // Holding start gives one event, so a stop while it is held stays paused.
        load(5, 10);
        n_startn = 1'b0; idle(6);
        n_stopn = 1'b0; step(); n_stopn = 1'b1;
        idle(14);
        n_startn = 1'b1; idle(2);
        press_clear();

        // Reset asserted mid-cook with the magnetron on.
        load(20, 10);
        press_start();
        idle(5);
        n_rst = 1'b1; idle(2);
        n_rst = 1'b0; idle(3);

        // Short cook followed by the beep window, then again with the door opened.
        load(2, 10);
        press_start();
        idle(30);
        press_clear();
        load(2, 10);
        press_start();
        idle(12);
        n_door = 1'b0; idle(3);
        n_door = 1'b1; idle(2);

        // Random stimulus.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 4)  == 0) n_startn = ~n_startn;
            if ($urandom_range(0, 14) == 0) n_stopn  = ~n_stopn;
            if ($urandom_range(0, 29) == 0) n_clearn = ~n_clearn;
            if ($urandom_range(0, 24) == 0) n_door   = ~n_door;
            n_load  = ($urandom_range(0, 11) == 0);
            n_time  = TW'($urandom_range(0, 12));
            n_power = PW'($urandom_range(0, 15));
            n_rst   = ($urandom_range(0, 399) == 0);
            step();
        end
        n_rst = 1'b0; n_startn = 1'b1; n_stopn = 1'b1; n_clearn = 1'b1;
        n_door = 1'b1; n_load = 1'b0;
        idle(3);

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
